// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//
// Shares BRAM data port B between the pipeline's data-memory access (core, C)
// and the program loader / debug master (L). Every cycle one requester at most
// is granted; its we/addr/wdata are steered onto the port. Read data returns
// one cycle after a read grant and is delivered to whoever owned that read,
// independent of who owns the port in the return cycle.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   c_req/c_we/c_addr/c_wdata  core request side
//   c_gnt                    core granted this cycle (combinational)
//   c_rvalid/c_rdata         core read response (cycle after read grant)
//   core_stall               core requesting but not granted
//   l_req/l_lock/l_we/l_addr/l_wdata  loader request side, l_lock keeps ownership
//   l_gnt                    loader granted this cycle (combinational)
//   l_rvalid/l_rdata         loader read response
//   mem_we/mem_addr/mem_wdata  to BRAM port B
//   mem_rdata                from BRAM port B (1-cycle registered latency)

module dmem_port_arbiter #(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned L_PRIO   = 1,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic          clk,
    input  logic          rst,

    // Core side
    input  logic          c_req,
    input  logic [3:0]    c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    output logic          core_stall,

    // Loader side
    input  logic          l_req,
    input  logic          l_lock,
    input  logic [3:0]    l_we,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    output logic          l_gnt,
    output logic          l_rvalid,
    output logic [DW-1:0] l_rdata,

    // BRAM port B
    output logic [3:0]    mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int unsigned CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] MaxWaitW = CW'(MAX_WAIT);
    localparam bit LPrio = (L_PRIO != 0);

    // Port owner during the previous cycle.
    typedef enum logic [1:0] {
        StIdle,
        StOwnC,
        StOwnL
    } state_e;

    // Requester whose read response is due this cycle.
    typedef enum logic [1:0] {
        RdNone,
        RdC,
        RdL
    } rd_owner_e;

    state_e          state_q, state_d;
    rd_owner_e       rd_owner_q, rd_owner_d;
    logic [CW-1:0]   wait_c_q, wait_c_d;
    logic [CW-1:0]   wait_l_q, wait_l_d;
    logic [DW-1:0]   c_rdata_q;
    logic [DW-1:0]   l_rdata_q;
    logic            grant_c;
    logic            grant_l;

    // ------------------------------------------------------------------
    // Grant decision
    // ------------------------------------------------------------------
    always_comb begin
        grant_c = 1'b0;
        grant_l = 1'b0;
        if (c_req && !l_req) begin
            grant_c = 1'b1;
        end else if (l_req && !c_req) begin
            grant_l = 1'b1;
        end else if (c_req && l_req) begin
            // Starvation bound beats both the lock and plain priority.
            if (LPrio && (wait_c_q == MaxWaitW)) begin
                grant_c = 1'b1;
            end else if (!LPrio && (wait_l_q == MaxWaitW)) begin
                grant_l = 1'b1;
            end else if ((state_q == StOwnL) && l_lock) begin
                grant_l = 1'b1;
            end else if (LPrio) begin
                grant_l = 1'b1;
            end else begin
                grant_c = 1'b1;
            end
        end
    end

    assign c_gnt      = grant_c;
    assign l_gnt      = grant_l;
    assign core_stall = c_req & ~grant_c;

    // ------------------------------------------------------------------
    // Port mux: an idle port drives all-zero so no stray write can occur
    // ------------------------------------------------------------------
    always_comb begin
        mem_we    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant_c) begin
            mem_we    = c_we;
            mem_addr  = c_addr;
            mem_wdata = c_wdata;
        end else if (grant_l) begin
            mem_we    = l_we;
            mem_addr  = l_addr;
            mem_wdata = l_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Next-state: owner, wait counters, pending read owner
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = StIdle;
        rd_owner_d = RdNone;
        if (grant_c) begin
            state_d = StOwnC;
            if (c_we == 4'b0000) begin
                rd_owner_d = RdC;
            end
        end else if (grant_l) begin
            state_d = StOwnL;
            if (l_we == 4'b0000) begin
                rd_owner_d = RdL;
            end
        end

        // Count only cycles spent requesting without a grant; saturate.
        wait_c_d = '0;
        if (c_req && !grant_c) begin
            wait_c_d = (wait_c_q == MaxWaitW) ? wait_c_q : wait_c_q + 1'b1;
        end
        wait_l_d = '0;
        if (l_req && !grant_l) begin
            wait_l_d = (wait_l_q == MaxWaitW) ? wait_l_q : wait_l_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            rd_owner_q <= RdNone;
            wait_c_q   <= '0;
            wait_l_q   <= '0;
            c_rdata_q  <= '0;
            l_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            rd_owner_q <= rd_owner_d;
            wait_c_q   <= wait_c_d;
            wait_l_q   <= wait_l_d;
            // Capture the response so rdata holds until the next valid.
            if (rd_owner_q == RdC) begin
                c_rdata_q <= mem_rdata;
            end
            if (rd_owner_q == RdL) begin
                l_rdata_q <= mem_rdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read response: routed by the registered owner, not the current grant
    // ------------------------------------------------------------------
    assign c_rvalid = (rd_owner_q == RdC);
    assign l_rvalid = (rd_owner_q == RdL);
    assign c_rdata  = c_rvalid ? mem_rdata : c_rdata_q;
    assign l_rdata  = l_rvalid ? mem_rdata : l_rdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Testbench for dmem_port_arbiter: directed scenarios followed by constrained
// random traffic, all checked against a cycle-level reference model.

module tb_dmem_port_arbiter;

    localparam int MAXW = 8;
    localparam int LP   = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_req, l_req, l_lock;
    logic [3:0]  c_we, l_we;
    logic [31:0] c_addr, c_wdata, l_addr, l_wdata;
    logic        c_gnt, c_rvalid, core_stall, l_gnt, l_rvalid;
    logic [31:0] c_rdata, l_rdata;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int checks   = 0;
    int failures = 0;
    string phase = "reset";

    // Reference model state: 0 = none, 1 = core, 2 = loader
    int          m_prev, m_wc, m_wl, m_pend;
    logic [31:0] m_crd, m_lrd;
    int          last_g;

    dmem_port_arbiter #(
        .AW(32), .DW(32), .L_PRIO(LP), .MAX_WAIT(MAXW)
    ) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .core_stall(core_stall),
        .l_req(l_req), .l_lock(l_lock), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s/%s observed=%h expected=%h", phase, tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prev = 0; m_wc = 0; m_wl = 0; m_pend = 0;
        m_crd = '0; m_lrd = '0; last_g = 0;
    endtask

    function automatic int model_grant();
        if (c_req && !l_req) return 1;
        if (l_req && !c_req) return 2;
        if (!c_req && !l_req) return 0;
        if (LP != 0 && m_wc == MAXW) return 1;
        if (LP == 0 && m_wl == MAXW) return 2;
        if (m_prev == 2 && l_lock) return 2;
        return (LP != 0) ? 2 : 1;
    endfunction

    // Sample at negedge, compare against model, then advance the model.
    task automatic cyc_check();
        int g;
        logic [3:0]  ewe;
        logic [31:0] ea, ew;
        @(negedge clk);
        g   = model_grant();
        ewe = (g == 1) ? c_we : (g == 2) ? l_we : 4'h0;
        ea  = (g == 1) ? c_addr : (g == 2) ? l_addr : 32'h0;
        ew  = (g == 1) ? c_wdata : (g == 2) ? l_wdata : 32'h0;
        check("c_gnt", 32'(c_gnt), 32'(g == 1));
        check("l_gnt", 32'(l_gnt), 32'(g == 2));
        check("core_stall", 32'(core_stall), 32'(c_req && g != 1));
        check("mem_we", 32'(mem_we), 32'(ewe));
        check("mem_addr", mem_addr, ea);
        check("mem_wdata", mem_wdata, ew);
        check("c_rvalid", 32'(c_rvalid), 32'(m_pend == 1));
        check("l_rvalid", 32'(l_rvalid), 32'(m_pend == 2));
        check("c_rdata", c_rdata, (m_pend == 1) ? mem_rdata : m_crd);
        check("l_rdata", l_rdata, (m_pend == 2) ? mem_rdata : m_lrd);
        if (m_pend == 1) m_crd = mem_rdata;
        if (m_pend == 2) m_lrd = mem_rdata;
        m_wc   = (c_req && g != 1) ? ((m_wc < MAXW) ? m_wc + 1 : MAXW) : 0;
        m_wl   = (l_req && g != 2) ? ((m_wl < MAXW) ? m_wl + 1 : MAXW) : 0;
        m_pend = (g == 1 && c_we == 4'h0) ? 1 : (g == 2 && l_we == 4'h0) ? 2 : 0;
        m_prev = g;
        last_g = g;
        if (rst) model_reset();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
        l_req = 0; l_lock = 0; l_we = 0; l_addr = 0; l_wdata = 0;
        mem_rdata = 0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        model_reset();

        // Reset state
        cyc_check();
        check("rst_c_rvalid", 32'(c_rvalid), 32'd0);
        check("rst_c_rdata", c_rdata, 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        adv();
        rst = 1'b0;

        // T1 core-only read
        phase = "t1";
        c_req = 1; c_we = 0; c_addr = 32'h40;
        cyc_check();
        check("t1_gnt", 32'(c_gnt), 32'd1);
        check("t1_stall", 32'(core_stall), 32'd0);
        check("t1_addr", mem_addr, 32'h40);
        adv();
        c_req = 0; mem_rdata = 32'hDEADBEEF;
        cyc_check();
        check("t1_rvalid", 32'(c_rvalid), 32'd1);
        check("t1_rdata", c_rdata, 32'hDEADBEEF);
        check("t1_l_rvalid", 32'(l_rvalid), 32'd0);
        adv();
        mem_rdata = 32'h0;
        cyc_check();
        check("t1_hold", c_rdata, 32'hDEADBEEF);
        adv();

        // T2 conflict, loader priority
        phase = "t2";
        c_req = 1; c_we = 0; c_addr = 32'h80;
        l_req = 1; l_we = 4'hF; l_addr = 32'h10; l_wdata = 32'h12345678;
        cyc_check();
        check("t2_l_gnt", 32'(l_gnt), 32'd1);
        check("t2_c_gnt", 32'(c_gnt), 32'd0);
        check("t2_we", 32'(mem_we), 32'hF);
        check("t2_addr", mem_addr, 32'h10);
        check("t2_stall", 32'(core_stall), 32'd1);
        adv();
        l_req = 0;
        cyc_check();
        check("t2_c_after", 32'(c_gnt), 32'd1);
        adv();
        c_req = 0; idle_inputs();
        cyc_check(); adv();

        // T3 lock holds the port for 5 cycles
        phase = "t3";
        c_req = 1; c_we = 0; c_addr = 32'h100;
        l_req = 1; l_lock = 1; l_we = 4'hF;
        for (int i = 0; i < 5; i++) begin
            l_addr = 32'h200 + 32'(i * 4); l_wdata = $urandom;
            cyc_check();
            check("t3_l_gnt", 32'(l_gnt), 32'd1);
            check("t3_stall", 32'(core_stall), 32'd1);
            adv();
        end
        idle_inputs();
        cyc_check(); adv();

        // T4 starvation bound overrides the lock
        phase = "t4";
        c_req = 1; c_we = 0; c_addr = 32'h300;
        l_req = 1; l_lock = 1; l_we = 4'h3;
        for (int i = 1; i <= 20; i++) begin
            l_addr = 32'h400 + 32'(i * 4);
            cyc_check();
            check("t4_c_gnt", 32'(c_gnt), 32'(i == 9 || i == 18));
            check("t4_l_gnt", 32'(l_gnt), 32'(i != 9 && i != 18));
            adv();
        end
        idle_inputs();
        cyc_check(); adv();

        // T5 read hand-off between owners
        phase = "t5";
        l_req = 1; l_we = 0; l_addr = 32'h20;
        cyc_check(); adv();
        l_req = 0; c_req = 1; c_we = 0; c_addr = 32'h24; mem_rdata = 32'hAAAA0001;
        cyc_check();
        check("t5_l_rvalid", 32'(l_rvalid), 32'd1);
        check("t5_l_rdata", l_rdata, 32'hAAAA0001);
        check("t5_c_rvalid0", 32'(c_rvalid), 32'd0);
        adv();
        c_req = 0; mem_rdata = 32'hCCCC0002;
        cyc_check();
        check("t5_c_rvalid", 32'(c_rvalid), 32'd1);
        check("t5_c_rdata", c_rdata, 32'hCCCC0002);
        check("t5_l_rvalid0", 32'(l_rvalid), 32'd0);
        check("t5_l_hold", l_rdata, 32'hAAAA0001);
        adv();

        // T6 reset right after a granted read
        phase = "t6";
        idle_inputs();
        c_req = 1; c_we = 0; c_addr = 32'h44;
        cyc_check(); adv();
        rst = 1'b1; c_req = 0; mem_rdata = 32'h5555AAAA;
        #1;
        model_reset();
        cyc_check();
        check("t6_c_rvalid", 32'(c_rvalid), 32'd0);
        check("t6_c_rdata", c_rdata, 32'h0);
        check("t6_l_rdata", l_rdata, 32'h0);
        adv();
        rst = 1'b0;
        cyc_check();
        check("t6_after", 32'(c_rvalid), 32'd0);
        adv();

        // Random traffic; requesters hold their request until granted
        phase = "rand";
        for (int n = 0; n < 600; n++) begin
            if (!(c_req && last_g != 1)) begin
                c_req   = ($urandom_range(0, 3) != 0);
                c_we    = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
                c_addr  = $urandom;
                c_wdata = $urandom;
            end
            if (!(l_req && last_g != 2)) begin
                l_req   = ($urandom_range(0, 3) != 0);
                l_we    = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
                l_addr  = $urandom;
                l_wdata = $urandom;
            end
            l_lock    = ($urandom_range(0, 9) < 7);
            mem_rdata = $urandom;
            cyc_check();
            adv();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
